// File: rtl/cache_arb_pkg.sv
// cache_arb_pkg: shared types and defaults for the I/D cache refill arbiter.
//   state_t  - arbiter FSM states
//   owner_t  - which requester currently owns the memory port
//   DEFAULT_ADDR_W / DEFAULT_DATA_W - default port widths
package cache_arb_pkg;

  localparam int DEFAULT_ADDR_W = 32;
  localparam int DEFAULT_DATA_W = 32;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT_RD = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  // The requester that did not own the port last time.
  function automatic owner_t other_owner(input owner_t o);
    return (o == OWN_I) ? OWN_D : OWN_I;
  endfunction

endpackage

// File: rtl/cache_mem_arbiter_rr2_grant.sv
// rr2_grant: combinational two-way round-robin grant.
//   req_i, req_d - request from the I and D side
//   last_owner   - requester that completed the previous transfer
//   owner        - granted requester (meaningful only when a request exists)
module rr2_grant
  import cache_arb_pkg::*;
(
  input  logic   req_i,
  input  logic   req_d,
  input  owner_t last_owner,
  output owner_t owner
);

  // A lone requester wins; on a tie the one that went last yields.
  always_comb begin
    owner = OWN_I;
    if (req_i && !req_d) begin
      owner = OWN_I;
    end else if (!req_i && req_d) begin
      owner = OWN_D;
    end else begin
      owner = other_owner(last_owner);
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one Avalon-MM master port between the I-side
// (read only) and D-side (read/write) cache refill paths, one transfer at a
// time, round-robin on ties, read data routed back to the issuing side.
//   clk, reset_n           - clock, synchronous active-low reset
//   i_*                    - I-side slave port (address, read, waitrequest,
//                            readdata, readdatavalid)
//   d_*                    - D-side slave port (adds write, byteenable,
//                            writedata)
//   m_*                    - master port to the memory slave
module cache_mem_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   i_address,
  input  logic                i_read,
  output logic                i_waitrequest,
  output logic [DATA_W-1:0]   i_readdata,
  output logic                i_readdatavalid,
  input  logic [ADDR_W-1:0]   d_address,
  input  logic                d_read,
  input  logic                d_write,
  input  logic [DATA_W/8-1:0] d_byteenable,
  input  logic [DATA_W-1:0]   d_writedata,
  output logic                d_waitrequest,
  output logic [DATA_W-1:0]   d_readdata,
  output logic                d_readdatavalid,
  output logic [ADDR_W-1:0]   m_address,
  output logic                m_read,
  output logic                m_write,
  output logic [DATA_W/8-1:0] m_byteenable,
  output logic [DATA_W-1:0]   m_writedata,
  input  logic                m_waitrequest,
  input  logic [DATA_W-1:0]   m_readdata,
  input  logic                m_readdatavalid
);

  localparam int BE_W = DATA_W / 8;

  state_t state, state_next;
  owner_t owner, owner_next;
  owner_t last_owner, last_owner_next;
  owner_t grant;
  // Transfer direction is captured at grant time so that m_read/m_write
  // depend only on registered state, never on the live request lines.
  logic   op_write, op_write_next;
  logic   req_i, req_d, owner_req, accept;

  assign req_i     = i_read;
  assign req_d     = d_read | d_write;
  assign owner_req = (owner == OWN_I) ? req_i : req_d;
  assign accept    = (state == S_ISSUE) && !m_waitrequest;

  rr2_grant u_grant (
    .req_i      (req_i),
    .req_d      (req_d),
    .last_owner (last_owner),
    .owner      (grant)
  );

  // State, owner and direction registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      owner      <= OWN_I;
      last_owner <= OWN_D;
      op_write   <= 1'b0;
    end else begin
      state      <= state_next;
      owner      <= owner_next;
      last_owner <= last_owner_next;
      op_write   <= op_write_next;
    end
  end

  // Next-state logic: grant in idle, wait for acceptance, wait for read data.
  always_comb begin
    state_next      = state;
    owner_next      = owner;
    last_owner_next = last_owner;
    op_write_next   = op_write;
    case (state)
      S_IDLE: begin
        if (req_i || req_d) begin
          state_next    = S_ISSUE;
          owner_next    = grant;
          // Read and write together from D is a write.
          op_write_next = (grant == OWN_D) && d_write;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (accept) begin
          last_owner_next = owner;
          state_next      = op_write ? S_IDLE : S_WAIT_RD;
        end else if (!owner_req) begin
          // Owner withdrew its request: give up rather than hang.
          state_next = S_IDLE;
        end else begin
          state_next = S_ISSUE;
        end
      end
      S_WAIT_RD: begin
        if (m_readdatavalid) begin
          state_next = S_IDLE;
        end else begin
          state_next = S_WAIT_RD;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Handshake outputs decoded from state, owner and m_waitrequest.
  always_comb begin
    m_read          = 1'b0;
    m_write         = 1'b0;
    i_waitrequest   = 1'b1;
    d_waitrequest   = 1'b1;
    i_readdatavalid = 1'b0;
    d_readdatavalid = 1'b0;
    case (state)
      S_ISSUE: begin
        m_read  = !op_write;
        m_write = op_write;
        if (owner == OWN_I) begin
          i_waitrequest = m_waitrequest;
        end else begin
          d_waitrequest = m_waitrequest;
        end
      end
      S_WAIT_RD: begin
        if (owner == OWN_I) begin
          i_readdatavalid = m_readdatavalid;
        end else begin
          d_readdatavalid = m_readdatavalid;
        end
      end
      default: begin
        m_read = 1'b0;
      end
    endcase
  end

  // Address/data path follows the registered owner.
  always_comb begin
    m_address    = i_address;
    m_byteenable = {BE_W{1'b1}};
    m_writedata  = {DATA_W{1'b0}};
    if (owner == OWN_D) begin
      m_address    = d_address;
      m_byteenable = d_byteenable;
      m_writedata  = d_writedata;
    end else begin
      m_address    = i_address;
      m_byteenable = {BE_W{1'b1}};
      m_writedata  = {DATA_W{1'b0}};
    end
  end

  assign i_readdata = m_readdata;
  assign d_readdata = m_readdata;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: self-checking bench for cache_mem_arbiter.
// A behavioural memory slave with configurable stall and read latency checks
// every accepted transfer against a queue of expected transfers, and a
// response monitor checks read data routing against a queue of expected
// responses. Two requester agents drive I and D commands from queues.
module tb_cache_mem_arbiter;

  logic        clk;
  logic        reset_n;
  logic [31:0] i_address;
  logic        i_read;
  logic        i_waitrequest;
  logic [31:0] i_readdata;
  logic        i_readdatavalid;
  logic [31:0] d_address;
  logic        d_read;
  logic        d_write;
  logic [3:0]  d_byteenable;
  logic [31:0] d_writedata;
  logic        d_waitrequest;
  logic [31:0] d_readdata;
  logic        d_readdatavalid;
  logic [31:0] m_address;
  logic        m_read;
  logic        m_write;
  logic [3:0]  m_byteenable;
  logic [31:0] m_writedata;
  logic        m_waitrequest;
  logic [31:0] m_readdata;
  logic        m_readdatavalid;

  cache_mem_arbiter dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .i_address       (i_address),
    .i_read          (i_read),
    .i_waitrequest   (i_waitrequest),
    .i_readdata      (i_readdata),
    .i_readdatavalid (i_readdatavalid),
    .d_address       (d_address),
    .d_read          (d_read),
    .d_write         (d_write),
    .d_byteenable    (d_byteenable),
    .d_writedata     (d_writedata),
    .d_waitrequest   (d_waitrequest),
    .d_readdata      (d_readdata),
    .d_readdatavalid (d_readdatavalid),
    .m_address       (m_address),
    .m_read          (m_read),
    .m_write         (m_write),
    .m_byteenable    (m_byteenable),
    .m_writedata     (m_writedata),
    .m_waitrequest   (m_waitrequest),
    .m_readdata      (m_readdata),
    .m_readdatavalid (m_readdatavalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] data; } xfer_t;
  typedef struct { logic port_d; logic [31:0] data; } rsp_t;
  typedef struct { logic we; logic rd; logic [31:0] addr; logic [3:0] be; logic [31:0] data; } dcmd_t;

  xfer_t       exp_xfer[$];
  rsp_t        exp_rsp[$];
  logic [31:0] i_q[$];
  dcmd_t       d_q[$];
  logic [31:0] mem [logic [31:0]];
  bit          agent_en = 1'b0;
  bit          i_busy   = 1'b0;
  bit          d_busy   = 1'b0;
  int          wait_c   = 0;
  int          rd_lat   = 1;

  // Memory slave: sample the handshake at negedge, drive responses after posedge.
  initial begin
    int          stall_left;
    int          rd_cnt;
    logic        req_seen, acc, acc_rd;
    logic [31:0] rd_data, word;
    xfer_t       x;
    stall_left = 0; rd_cnt = 0; rd_data = 32'h0;
    m_waitrequest = 1'b0; m_readdatavalid = 1'b0; m_readdata = 32'h0;
    forever begin
      @(negedge clk);
      req_seen = (m_read === 1'b1) || (m_write === 1'b1);
      acc      = req_seen && (m_waitrequest === 1'b0);
      acc_rd   = acc && (m_read === 1'b1);
      if (acc) begin
        check("xfer_pending", 32'(exp_xfer.size() != 0), 32'd1);
        if (exp_xfer.size() != 0) begin
          x = exp_xfer.pop_front();
          check("xfer_we", 32'(m_write), 32'(x.we));
          check("xfer_rd", 32'(m_read), 32'(!x.we));
          check("xfer_addr", m_address, x.addr);
          check("xfer_be", 32'(m_byteenable), 32'(x.be));
          if (x.we) check("xfer_wdata", m_writedata, x.data);
        end
        word = mem.exists(m_address) ? mem[m_address] : 32'h0;
        if (m_write === 1'b1) begin
          for (int b = 0; b < 4; b++)
            if (m_byteenable[b]) word[8*b +: 8] = m_writedata[8*b +: 8];
          mem[m_address] = word;
        end else begin
          rd_data = word;
        end
      end
      @(posedge clk); #1;
      m_readdatavalid = 1'b0;
      m_readdata      = $urandom;
      if (acc_rd) rd_cnt = rd_lat;
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          m_readdatavalid = 1'b1;
          m_readdata      = rd_data;
        end
      end
      if (!req_seen || acc) stall_left = wait_c;
      else if (stall_left > 0) stall_left--;
      m_waitrequest = (stall_left != 0);
    end
  end

  // Response monitor: every readdatavalid must match the next expected response.
  always @(negedge clk) begin
    rsp_t r;
    if ((i_readdatavalid === 1'b1) || (d_readdatavalid === 1'b1)) begin
      check("rsp_pending", 32'(exp_rsp.size() != 0), 32'd1);
      if (exp_rsp.size() != 0) begin
        r = exp_rsp.pop_front();
        check("rsp_port_d", 32'(d_readdatavalid), 32'(r.port_d));
        check("rsp_port_i", 32'(i_readdatavalid), 32'(!r.port_d));
        check("rsp_data", r.port_d ? d_readdata : i_readdata, r.data);
      end
    end
  end

  // I-side agent: present queued reads back to back, each held until accepted.
  initial begin
    int cyc;
    forever begin
      @(posedge clk); #1;
      while (agent_en && i_q.size() != 0) begin
        i_busy = 1'b1; i_address = i_q.pop_front(); i_read = 1'b1;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (i_waitrequest !== 1'b0 && cyc < 200);
        if (i_waitrequest !== 1'b0) check("i_grant_timeout", 32'(i_waitrequest), 32'd0);
        @(posedge clk); #1;
      end
      if (agent_en) begin i_read = 1'b0; i_busy = 1'b0; end
    end
  end

  // D-side agent: same protocol with read/write commands.
  initial begin
    int    cyc;
    dcmd_t c;
    forever begin
      @(posedge clk); #1;
      while (agent_en && d_q.size() != 0) begin
        d_busy = 1'b1; c = d_q.pop_front();
        d_address = c.addr; d_read = c.rd; d_write = c.we;
        d_byteenable = c.be; d_writedata = c.data;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (d_waitrequest !== 1'b0 && cyc < 200);
        if (d_waitrequest !== 1'b0) check("d_grant_timeout", 32'(d_waitrequest), 32'd0);
        @(posedge clk); #1;
      end
      if (agent_en) begin d_read = 1'b0; d_write = 1'b0; d_busy = 1'b0; end
    end
  end

  task automatic wait_idle(input string name);
    int cyc = 0;
    while (!(i_q.size() == 0 && d_q.size() == 0 && !i_busy && !d_busy &&
             exp_xfer.size() == 0 && exp_rsp.size() == 0) && cyc < 3000) begin
      @(negedge clk); cyc++;
    end
    check({name, "_drain"}, 32'(exp_xfer.size() + exp_rsp.size() + i_q.size() + d_q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    logic port_d; logic we; logic [31:0] addr; logic [3:0] be;
    logic [31:0] wdata; int wait_c; int lat; logic [31:0] rdata;
  } vec_t;
  localparam int NV = 9;
  vec_t tbl [NV];

  // Global watchdog.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt_i, cnt_d, cyc;

    tbl[0] = '{1'b1, 1'b1, 32'h20, 4'hF, 32'h1122_3344, 0, 1, 32'h0};
    tbl[1] = '{1'b1, 1'b1, 32'h24, 4'hF, 32'hcafe_f00d, 2, 1, 32'h0};
    tbl[2] = '{1'b0, 1'b0, 32'h20, 4'hF, 32'h0,         0, 1, 32'h1122_3344};
    tbl[3] = '{1'b1, 1'b1, 32'h20, 4'h5, 32'haabb_ccdd, 0, 1, 32'h0};
    tbl[4] = '{1'b1, 1'b0, 32'h20, 4'hF, 32'h0,         0, 2, 32'h11bb_33dd};
    tbl[5] = '{1'b0, 1'b0, 32'h24, 4'hF, 32'h0,         3, 4, 32'hcafe_f00d};
    tbl[6] = '{1'b1, 1'b1, 32'h28, 4'h8, 32'h1234_5678, 0, 1, 32'h0};
    tbl[7] = '{1'b0, 1'b0, 32'h28, 4'hF, 32'h0,         1, 1, 32'h1200_0000};
    tbl[8] = '{1'b1, 1'b0, 32'h30, 4'hF, 32'h0,         0, 3, 32'h0};

    mem[32'h4]  = 32'h0bad_0004;
    mem[32'h10] = 32'h1010_abcd;
    for (int k = 0; k < 50; k++) mem[32'h100 + 32'(4*k)] = 32'h1000_0000 + 32'(k);

    // Reset held with both sides requesting: nothing may be issued.
    reset_n = 1'b0;
    i_read = 1'b1; i_address = 32'h4;
    d_read = 1'b0; d_write = 1'b1; d_address = 32'h80;
    d_byteenable = 4'hF; d_writedata = 32'h8080_8080;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("rst_m_read", 32'(m_read), 32'd0);
      check("rst_m_write", 32'(m_write), 32'd0);
      check("rst_i_wait", 32'(i_waitrequest), 32'd1);
      check("rst_d_wait", 32'(d_waitrequest), 32'd1);
      check("rst_rdv", 32'({i_readdatavalid, d_readdatavalid}), 32'd0);
    end
    exp_xfer.push_back('{1'b0, 32'h4, 4'hF, 32'h0});
    exp_xfer.push_back('{1'b1, 32'h80, 4'hF, 32'h8080_8080});
    exp_rsp.push_back('{1'b0, 32'h0bad_0004});
    i_q.push_back(32'h4);
    d_q.push_back('{1'b1, 1'b0, 32'h80, 4'hF, 32'h8080_8080});
    agent_en = 1'b1;
    reset_n  = 1'b1;
    @(negedge clk);
    check("first_grant_m_read", 32'(m_read), 32'd1);
    check("first_grant_m_write", 32'(m_write), 32'd0);
    check("first_grant_addr", m_address, 32'h4);
    check("first_grant_i_wait", 32'(i_waitrequest), 32'd0);
    check("first_grant_d_wait", 32'(d_waitrequest), 32'd1);
    wait_idle("reset");

    // Table of single-requester transfers.
    for (int v = 0; v < NV; v++) begin
      @(negedge clk);
      wait_c = tbl[v].wait_c;
      rd_lat = tbl[v].lat;
      exp_xfer.push_back('{tbl[v].we, tbl[v].addr, tbl[v].port_d ? tbl[v].be : 4'hF, tbl[v].wdata});
      if (!tbl[v].we) exp_rsp.push_back('{tbl[v].port_d, tbl[v].rdata});
      if (tbl[v].port_d) d_q.push_back('{tbl[v].we, !tbl[v].we, tbl[v].addr, tbl[v].be, tbl[v].wdata});
      else i_q.push_back(tbl[v].addr);
      wait_idle($sformatf("vec%0d", v));
    end

    // Simultaneous I read and D write; I wins the tie, then D reads back.
    @(negedge clk);
    wait_c = 0; rd_lat = 2;
    exp_xfer.push_back('{1'b0, 32'h4, 4'hF, 32'h0});
    exp_xfer.push_back('{1'b1, 32'h8, 4'h7, 32'hdead_0008});
    exp_rsp.push_back('{1'b0, 32'h0bad_0004});
    i_q.push_back(32'h4);
    d_q.push_back('{1'b1, 1'b0, 32'h8, 4'h7, 32'hdead_0008});
    wait_idle("simul");
    @(negedge clk);
    exp_xfer.push_back('{1'b0, 32'h8, 4'hF, 32'h0});
    exp_rsp.push_back('{1'b1, 32'h00ad_0008});
    d_q.push_back('{1'b0, 1'b1, 32'h8, 4'hF, 32'h0});
    wait_idle("readback");

    // Fairness: both sides continuously busy, grants must alternate I,D,...
    @(negedge clk);
    rd_lat = 1;
    for (int k = 0; k < 50; k++) begin
      exp_xfer.push_back('{1'b0, 32'h100 + 32'(4*k), 4'hF, 32'h0});
      exp_xfer.push_back('{1'b1, 32'h200 + 32'(4*k), 4'hF, 32'hf000_0000 | 32'(k)});
      exp_rsp.push_back('{1'b0, 32'h1000_0000 + 32'(k)});
      i_q.push_back(32'h100 + 32'(4*k));
      d_q.push_back('{1'b1, 1'b0, 32'h200 + 32'(4*k), 4'hF, 32'hf000_0000 | 32'(k)});
    end
    wait_idle("fair");

    // Stall: five waitrequest cycles on a D write, then a one-cycle release.
    @(negedge clk);
    wait_c = 5;
    exp_xfer.push_back('{1'b1, 32'h40, 4'hF, 32'h55aa_55aa});
    d_q.push_back('{1'b1, 1'b0, 32'h40, 4'hF, 32'h55aa_55aa});
    cyc = 0;
    while (m_write !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
    check("stall_start", 32'(m_write), 32'd1);
    for (int k = 0; k < 5; k++) begin
      check("stall_m_write", 32'(m_write), 32'd1);
      check("stall_addr", m_address, 32'h40);
      check("stall_wdata", m_writedata, 32'h55aa_55aa);
      check("stall_be", 32'(m_byteenable), 32'hF);
      check("stall_d_wait", 32'(d_waitrequest), 32'd1);
      @(negedge clk);
    end
    check("stall_release_d_wait", 32'(d_waitrequest), 32'd0);
    @(negedge clk);
    check("stall_pulse_end", 32'(d_waitrequest), 32'd1);
    wait_idle("stall");
    wait_c = 0;

    // Read routing: D read with latency 3 pulses only d_readdatavalid once.
    @(negedge clk);
    rd_lat = 3;
    exp_xfer.push_back('{1'b0, 32'h10, 4'hF, 32'h0});
    exp_rsp.push_back('{1'b1, 32'h1010_abcd});
    d_q.push_back('{1'b0, 1'b1, 32'h10, 4'hF, 32'h0});
    cnt_i = 0; cnt_d = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (i_readdatavalid === 1'b1) cnt_i++;
      if (d_readdatavalid === 1'b1) cnt_d++;
    end
    check("route_d_pulses", 32'(cnt_d), 32'd1);
    check("route_i_pulses", 32'(cnt_i), 32'd0);
    wait_idle("route");

    // Reset in the middle of a read; the late data must be dropped.
    @(negedge clk);
    rd_lat = 8;
    exp_xfer.push_back('{1'b0, 32'h14, 4'hF, 32'h0});
    d_q.push_back('{1'b0, 1'b1, 32'h14, 4'hF, 32'h0});
    cyc = 0;
    while (!(m_read === 1'b1 && m_waitrequest === 1'b0) && cyc < 50) begin @(negedge clk); cyc++; end
    check("midrd_accept", 32'(m_read), 32'd1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    cnt_i = 0; cnt_d = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (i_readdatavalid === 1'b1) cnt_i++;
      if (d_readdatavalid === 1'b1) cnt_d++;
    end
    check("midrd_i_rdv", 32'(cnt_i), 32'd0);
    check("midrd_d_rdv", 32'(cnt_d), 32'd0);
    check("midrd_m_read_idle", 32'(m_read), 32'd0);
    rd_lat = 1;
    exp_xfer.push_back('{1'b0, 32'h4, 4'hF, 32'h0});
    exp_rsp.push_back('{1'b0, 32'h0bad_0004});
    i_q.push_back(32'h4);
    wait_idle("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Two-requester arbiter sharing one Avalon-MM memory master port between the instruction-side and data-side cache refill paths of the cache subsystem. It accepts single-word Avalon-MM transfers from the I port (read-only) and D port (read/write with byte enables) and forwards exactly one at a time to memory. Ties are resolved round-robin, and read data is routed back to the requester that issued the read. It sits between the cache controllers and the on-chip RAM/SDRAM slave.

## Interface
- ADDR_W, 32, byte address width on all ports
- DATA_W, 32, data width; byte enable width is DATA_W/8
- clk  in  1  system clock
- reset_n  in  1  reset; one clock; reset is synchronous and active-low
- i_address  in  ADDR_W  I-side address
- i_read  in  1  I-side read request
- i_waitrequest  out  1  I-side stall
- i_readdata  out  DATA_W  I-side read data
- i_readdatavalid  out  1  I-side read data valid
- d_address  in  ADDR_W  D-side address
- d_read, d_write  in  1  D-side requests
- d_byteenable  in  DATA_W/8  D-side byte enables
- d_writedata  in  DATA_W  D-side write data
- d_waitrequest  out  1  D-side stall
- d_readdata  out  DATA_W  D-side read data
- d_readdatavalid  out  1  D-side read data valid
- m_address  out  ADDR_W  memory address
- m_read, m_write  out  1  memory requests
- m_byteenable  out  DATA_W/8  memory byte enables
- m_writedata  out  DATA_W  memory write data
- m_waitrequest  in  1  memory stall
- m_readdata  in  DATA_W  memory read data
- m_readdatavalid  in  1  memory read data valid

## Operation
- FSM states: S_IDLE, S_ISSUE, S_WAIT_RD. Owner register: OWN_I or OWN_D. last_owner register.
- S_IDLE: if only I requests, owner<=OWN_I; if only D requests, owner<=OWN_D; if both, owner<=opposite of last_owner. With any request, go to S_ISSUE. Otherwise stay.
- S_ISSUE: m_* driven combinationally from the owner's live inputs. I-owned transfers drive m_write=0 and m_byteenable=all ones. Requesters hold inputs stable while waitrequest is high.
- Acceptance happens when m_waitrequest=0 in S_ISSUE. In that cycle the owner's waitrequest is 0, and last_owner<=owner. A read goes to S_WAIT_RD; a write goes to S_IDLE.
- S_WAIT_RD: m_readdata fans out to both readdata outputs. m_readdatavalid gates only the owner's readdatavalid. On valid, go to S_IDLE.
- d_read and d_write both high is treated as a write.
- m_readdatavalid outside S_WAIT_RD is dropped. Neither requester sees valid.
- A non-owner's waitrequest stays 1 throughout.

## Timing
- Reset values: state=S_IDLE, last_owner=OWN_D (so I wins the first tie), m_read=m_write=0, i/d_waitrequest=1, i/d_readdatavalid=0.
- All outputs other than pass-through data are decoded from registered state, owner and m_waitrequest. There is no combinational path from i_*/d_* requests to m_read/m_write.
- Minimum write latency: request in cycle N (S_IDLE), accepted in N+1 if m_waitrequest=0. The next arbitration occurs in N+2.
- Minimum read latency: issue in N+1; data in the same cycle as m_readdatavalid, earliest N+2.
- One transfer is outstanding at most. Memory throughput is at most one write per 2 cycles, or one read per 2 cycles plus memory latency.
- Round-robin guarantees that a requester held continuously is granted within one transfer of the other requester.
- Reset asserted mid-transfer: the next edge forces reset values and the in-flight read is abandoned. A late m_readdatavalid is dropped per the rule above.
- A requester dropping its request in S_ISSUE is a protocol violation. Behaviour is unspecified, but the FSM must not lock up: no request while in S_ISSUE returns it to S_IDLE.

## Structure
- Package cache_arb_pkg: state_t enum {S_IDLE, S_ISSUE, S_WAIT_RD}, owner_t enum {OWN_I, OWN_D}, and the default ADDR_W/DATA_W localparams.
- Sub-module rr2_grant: 2-way round-robin grant from (req_i, req_d, last_owner) to owner_t, combinational. The FSM, muxing and response routing live in cache_mem_arbiter.

## Test plan
- Reset: hold reset_n=0 for 10 cycles with i_read=d_write=1 -> m_read=m_write=0 and both waitrequests=1 throughout. The first grant goes to I one cycle after release.
- Simultaneous: I read 0x4 and D write 0x8 (BE=0111, data 0xdead0008) -> I read issued first and D write issued next. A read-back of 0x8 returns 0x00ad0008 on d_readdata only.
- Fairness: I and D both request continuously for 100 transfers -> grants strictly alternate I,D,I,D and no requester waits more than one foreign transfer.
- Stall: m_waitrequest=1 for 5 cycles on a D write -> m_* stay stable and d_waitrequest=1. On release, d_waitrequest=0 for exactly 1 cycle.
- Read routing: D read 0x10 with memory latency 3 -> only d_readdatavalid pulses, for 1 cycle, with m_readdata; i_readdatavalid stays 0.
- Reset mid-read: assert reset_n=0 in S_WAIT_RD, then deliver m_readdatavalid after release -> no readdatavalid on either port, and the next request is serviced normally.
